// File: rtl/sram_scan_cfg_if.sv
// Scan/load handshake bundle for sram_scan_cfg. The master drives scan and load
// requests, and the slave returns readback, status and the shadow configuration.
interface sram_scan_cfg_if #(
    parameter int SIZE  = 16,
    parameter int LANES = 1
);
    logic                  scan_en;
    logic [LANES-1:0]      scan_in;
    logic [LANES-1:0]      scan_out;
    logic                  load_start;
    logic                  load_busy;
    logic                  load_done;
    logic                  parity_err;
    logic                  cfg_valid;
    logic [SIZE*LANES-1:0] sram_data;

    modport master (
        output scan_en, scan_in, load_start,
        input  scan_out, load_busy, load_done, parity_err, cfg_valid, sram_data
    );

    modport slave (
        input  scan_en, scan_in, load_start,
        output scan_out, load_busy, load_done, parity_err, cfg_valid, sram_data
    );
endinterface

// File: rtl/sram_scan_cfg.sv
// sram_scan_cfg: LANES scan chains of SIZE bits feeding a glitch-free shadow config register.
// Defining SCAN_PARITY_EN adds a trailing even-parity bit to each lane, and a load with bad parity is rejected.
//
// state  | meaning
// IDLE   | waiting for load_start; shadow config stable
// SHIFT  | shifting NBITS bits per lane while scan_en is high
// COMMIT | one cycle: copy shift regs to shadow (or reject on parity error)
module sram_scan_cfg #(
    parameter int SIZE  = 16,
    parameter int LANES = 1
) (
    input  logic           scan_clk,
    input  logic           scan_rst,
    sram_scan_cfg_if.slave bus
);
    localparam int CNT_W = $clog2(SIZE + 2);
`ifdef SCAN_PARITY_EN
    localparam int NBITS = SIZE + 1;
`else
    localparam int NBITS = SIZE;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [LANES-1:0][SIZE-1:0]   shift_q, shift_d;
    logic [SIZE*LANES-1:0]        sram_q, sram_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         load_done_q, load_done_d;
    logic                         cfg_valid_q, cfg_valid_d;
    logic [LANES-1:0]             scan_out_w;

`ifdef SCAN_PARITY_EN
    logic [LANES-1:0]             par_q, par_d;
    logic                         parity_err_q, parity_err_d;
    logic                         par_bad;

    // A lane is bad when its data bits plus the received parity bit have odd weight.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            par_bad = par_bad | (^shift_q[i] ^ par_q[i]);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        sram_d      = sram_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        cfg_valid_d = cfg_valid_q;
`ifdef SCAN_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    for (int i = 0; i < LANES; i++) begin
                        shift_d[i] = sram_q[i*SIZE +: SIZE];
`ifdef SCAN_PARITY_EN
                        par_d[i] = ^sram_q[i*SIZE +: SIZE];
`endif
                    end
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.scan_en) begin
                    for (int i = 0; i < LANES; i++) begin
`ifdef SCAN_PARITY_EN
                        // The parity flop is the tail of the chain, below bit 0.
                        shift_d[i] = {shift_q[i][SIZE-2:0], par_q[i]};
                        par_d[i]   = bus.scan_in[i];
`else
                        shift_d[i] = {shift_q[i][SIZE-2:0], bus.scan_in[i]};
`endif
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
`ifdef SCAN_PARITY_EN
                if (par_bad) begin
                    parity_err_d = 1'b1;
                end else begin
                    sram_d      = shift_q;
                    load_done_d = 1'b1;
                    cfg_valid_d = 1'b1;
                end
`else
                sram_d      = shift_q;
                load_done_d = 1'b1;
                cfg_valid_d = 1'b1;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            sram_q      <= '0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            cfg_valid_q <= 1'b0;
`ifdef SCAN_PARITY_EN
            par_q        <= '0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            sram_q      <= sram_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
            cfg_valid_q <= cfg_valid_d;
`ifdef SCAN_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        scan_out_w = '0;
        for (int i = 0; i < LANES; i++) begin
            scan_out_w[i] = shift_q[i][SIZE-1];
        end
    end

    assign bus.scan_out  = scan_out_w;
    assign bus.load_busy = (state_q != IDLE);
    assign bus.load_done = load_done_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.sram_data = sram_q;
`ifdef SCAN_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_scan_cfg.sv
// Self-checking bench for sram_scan_cfg (SIZE=16, LANES=2) against a word-level model
// of the committed configuration and the expected readback stream.
module tb_sram_scan_cfg;
    localparam int SIZE  = 16;
    localparam int LANES = 2;
`ifdef SCAN_PARITY_EN
    localparam int NB = SIZE + 1;
`else
    localparam int NB = SIZE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_scan_cfg_if #(.SIZE(SIZE), .LANES(LANES)) bus ();

    sram_scan_cfg #(.SIZE(SIZE), .LANES(LANES)) dut (
        .scan_clk (clk),
        .scan_rst (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Word-level reference model.
    logic [31:0] exp_sram  = '0;
    logic        exp_valid = 1'b0;

    // Results recorded by run_load.
    int          r_cyc;
    logic [15:0] r_rb0, r_rb1;
    logic [1:0]  r_rbp;
    logic        r_got_done, r_got_perr, r_stable, r_stall_ok, r_pulse_low;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete load. Edge 1 is the capture edge; r_cyc counts edges up to and including the edge that raises done or perr.
    task automatic run_load(input logic [15:0] d0, input logic [15:0] d1,
                            input logic p0, input logic p1,
                            input int stall_at, input int stall_len, input logic hold);
        logic [31:0] pre;
        logic [1:0]  so;
        pre = bus.sram_data;
        r_stable = 1'b1; r_stall_ok = 1'b1; r_got_done = 1'b0; r_got_perr = 1'b0;
        r_pulse_low = 1'b1; r_rbp = '0;
        bus.load_start = 1'b1;
        bus.scan_en    = 1'b0;
        tick();
        r_cyc = 1;
        if (!hold) bus.load_start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    so = bus.scan_out;
                    bus.scan_en = 1'b0;
                    tick();
                    r_cyc++;
                    if (bus.load_busy !== 1'b1 || bus.scan_out !== so || bus.sram_data !== pre)
                        r_stall_ok = 1'b0;
                end
            end
            if (k < SIZE) begin
                r_rb1[15-k] = bus.scan_out[1];
                r_rb0[15-k] = bus.scan_out[0];
                bus.scan_in = {d1[15-k], d0[15-k]};
            end else begin
                r_rbp = bus.scan_out;
                bus.scan_in = {p1, p0};
            end
            bus.scan_en = 1'b1;
            tick();
            r_cyc++;
            if (bus.sram_data !== pre) r_stable = 1'b0;
        end
        bus.scan_en = 1'b0;
        bus.scan_in = $urandom_range(0, 3);
        while (!r_got_done && !r_got_perr && r_cyc < 60) begin
            tick();
            r_cyc++;
            r_got_done = bus.load_done;
            r_got_perr = bus.parity_err;
        end
        if (!hold && (r_got_done || r_got_perr)) begin
            tick();
            r_pulse_low = (bus.load_done === 1'b0) && (bus.parity_err === 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_sram = '0; exp_valid = 1'b0;
        n_checks++;
        if (bus.sram_data !== 32'h0) begin n_fail++; $display("FAIL reset_sram got=%h exp=%h", bus.sram_data, 32'h0); end
        n_checks++;
        if ({bus.load_busy, bus.load_done, bus.cfg_valid, bus.parity_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got busy/done/valid/perr=%b exp=0000",
                               {bus.load_busy, bus.load_done, bus.cfg_valid, bus.parity_err});
        end
        n_checks++;
        if (bus.scan_out !== 2'b00) begin n_fail++; $display("FAIL reset_scan_out got=%b exp=00", bus.scan_out); end
    endtask

    task automatic test_load();
        run_load(16'hA5C3, 16'h1234, ^16'hA5C3, ^16'h1234, -1, 0, 1'b0);
        exp_sram = 32'h1234_A5C3; exp_valid = 1'b1;
        n_checks++;
        if (r_got_done !== 1'b1 || r_cyc != NB + 2) begin
            n_fail++; $display("FAIL load_latency got done=%b cyc=%0d exp done=1 cyc=%0d", r_got_done, r_cyc, NB + 2);
        end
        n_checks++;
        if (bus.sram_data !== exp_sram) begin n_fail++; $display("FAIL load_data got=%h exp=%h", bus.sram_data, exp_sram); end
        n_checks++;
        if (bus.cfg_valid !== 1'b1 || bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL load_status got valid=%b busy=%b exp valid=1 busy=0", bus.cfg_valid, bus.load_busy);
        end
        n_checks++;
        if (r_pulse_low !== 1'b1 || r_stable !== 1'b1) begin
            n_fail++; $display("FAIL load_pulse_stable got pulse_low=%b stable=%b exp 1 1", r_pulse_low, r_stable);
        end
    endtask

    task automatic test_readback();
        logic [31:0] old;
        old = exp_sram;
        run_load(16'h0000, 16'h0000, 1'b0, 1'b0, -1, 0, 1'b0);
        exp_sram = '0;
        n_checks++;
        if ({r_rb1, r_rb0} !== old) begin n_fail++; $display("FAIL readback_stream got=%h exp=%h", {r_rb1, r_rb0}, old); end
`ifdef SCAN_PARITY_EN
        n_checks++;
        if (r_rbp !== {^old[31:16], ^old[15:0]}) begin
            n_fail++; $display("FAIL readback_parity got=%b exp=%b", r_rbp, {^old[31:16], ^old[15:0]});
        end
`endif
        n_checks++;
        if (r_stable !== 1'b1) begin n_fail++; $display("FAIL readback_hold got stable=%b exp=1", r_stable); end
        n_checks++;
        if (bus.sram_data !== exp_sram || bus.cfg_valid !== exp_valid) begin
            n_fail++; $display("FAIL readback_commit got=%h valid=%b exp=%h valid=%b", bus.sram_data, bus.cfg_valid, exp_sram, exp_valid);
        end
    endtask

    task automatic test_stall();
        run_load(16'hBEEF, 16'hCAFE, ^16'hBEEF, ^16'hCAFE, 7, 5, 1'b0);
        exp_sram = 32'hCAFE_BEEF; exp_valid = 1'b1;
        n_checks++;
        if (r_stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_frozen got ok=%b exp=1", r_stall_ok); end
        n_checks++;
        if (r_cyc != NB + 2 + 5) begin n_fail++; $display("FAIL stall_latency got=%0d exp=%0d", r_cyc, NB + 7); end
        n_checks++;
        if (bus.sram_data !== exp_sram) begin n_fail++; $display("FAIL stall_data got=%h exp=%h", bus.sram_data, exp_sram); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, a1;
        a0 = 16'h8001; a1 = 16'h7FFE;
        run_load(a0, a1, ^a0, ^a1, -1, 0, 1'b1);
        exp_sram = {a1, a0}; exp_valid = 1'b1;
        n_checks++;
        if (r_got_done !== 1'b1 || bus.sram_data !== exp_sram) begin
            n_fail++; $display("FAIL b2b_commit got done=%b data=%h exp done=1 data=%h", r_got_done, bus.sram_data, exp_sram);
        end
        tick();
        n_checks++;
        if (bus.load_busy !== 1'b1 || bus.scan_out !== {a1[15], a0[15]}) begin
            n_fail++; $display("FAIL b2b_restart got busy=%b scan_out=%b exp busy=1 scan_out=%b",
                               bus.load_busy, bus.scan_out, {a1[15], a0[15]});
        end
        bus.load_start = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic saw_done;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.scan_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.scan_in = $urandom_range(0, 3);
            tick();
        end
        rst = 1'b1;
        bus.load_start = 1'b1;
        tick();
        rst = 1'b0;
        bus.load_start = 1'b0;
        bus.scan_en = 1'b0;
        exp_sram = '0; exp_valid = 1'b0;
        n_checks++;
        if (bus.load_busy !== 1'b0 || bus.sram_data !== 32'h0 || bus.cfg_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state got busy=%b data=%h valid=%b exp 0 0 0", bus.load_busy, bus.sram_data, bus.cfg_valid);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (bus.load_done) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done !== 1'b0 || bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_nodone got done_seen=%b busy=%b exp 0 0", saw_done, bus.load_busy);
        end
        run_load(16'h5A5A, 16'h0F0F, ^16'h5A5A, ^16'h0F0F, -1, 0, 1'b0);
        exp_sram = 32'h0F0F_5A5A; exp_valid = 1'b1;
        n_checks++;
        if (bus.sram_data !== exp_sram || r_got_done !== 1'b1 || r_cyc != NB + 2 || bus.cfg_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_reload got data=%h done=%b cyc=%0d exp data=%h done=1 cyc=%0d",
                               bus.sram_data, r_got_done, r_cyc, exp_sram, NB + 2);
        end
    endtask

    task automatic test_random();
        logic [15:0] d0, d1;
        logic [31:0] old;
        int sa, sl;
        for (int it = 0; it < 5; it++) begin
            d0 = 16'($urandom); d1 = 16'($urandom);
            sa = $urandom_range(1, 14); sl = $urandom_range(0, 4);
            old = exp_sram;
            run_load(d0, d1, ^d0, ^d1, sa, sl, 1'b0);
            exp_sram = {d1, d0}; exp_valid = 1'b1;
            n_checks++;
            if ({r_rb1, r_rb0} !== old) begin n_fail++; $display("FAIL rand_readback it=%0d got=%h exp=%h", it, {r_rb1, r_rb0}, old); end
            n_checks++;
            if (r_cyc != NB + 2 + sl || r_got_done !== 1'b1) begin
                n_fail++; $display("FAIL rand_latency it=%0d got=%0d done=%b exp=%0d", it, r_cyc, r_got_done, NB + 2 + sl);
            end
            n_checks++;
            if (bus.sram_data !== exp_sram || r_stable !== 1'b1 || r_stall_ok !== 1'b1) begin
                n_fail++; $display("FAIL rand_data it=%0d got=%h stable=%b stall_ok=%b exp=%h",
                                   it, bus.sram_data, r_stable, r_stall_ok, exp_sram);
            end
        end
    endtask

`ifdef SCAN_PARITY_EN
    task automatic test_parity();
        logic [31:0] old;
        old = exp_sram;
        run_load(16'h00FF, 16'h3C3C, 1'b1, ^16'h3C3C, -1, 0, 1'b0);
        n_checks++;
        if (r_got_perr !== 1'b1 || r_got_done !== 1'b0 || r_pulse_low !== 1'b1) begin
            n_fail++; $display("FAIL parity_reject got perr=%b done=%b pulse_low=%b exp 1 0 1", r_got_perr, r_got_done, r_pulse_low);
        end
        n_checks++;
        if (bus.sram_data !== old || bus.cfg_valid !== exp_valid) begin
            n_fail++; $display("FAIL parity_hold got=%h valid=%b exp=%h valid=%b", bus.sram_data, bus.cfg_valid, old, exp_valid);
        end
        run_load(16'h00FF, 16'h3C3C, 1'b0, ^16'h3C3C, -1, 0, 1'b0);
        exp_sram = 32'h3C3C_00FF; exp_valid = 1'b1;
        n_checks++;
        if (r_got_done !== 1'b1 || r_got_perr !== 1'b0 || bus.sram_data !== exp_sram) begin
            n_fail++; $display("FAIL parity_accept got done=%b perr=%b data=%h exp 1 0 %h", r_got_done, r_got_perr, bus.sram_data, exp_sram);
        end
    endtask
`endif

    initial begin
        bus.scan_en    = 1'b0;
        bus.scan_in    = '0;
        bus.load_start = 1'b0;
        #1;
        test_reset();
        test_load();
        test_readback();
        test_stall();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
`ifdef SCAN_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
